run_launcher: RTL

- Initiator side of the processor's start/ack handshake.
- Drives `start` and waits for `ack` for each of a series of program runs. Measures the cycles of every run and flags runs that exceed a timeout.
- Sits between the bench or host and the processor top level.
- Lets one `go` command run NUM programs back-to-back without bench sequencing.

---
 rtl/run_launcher_if.sv | 41 ++++
 rtl/run_launcher.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/run_launcher_if.sv
// Handshake bundle for run_launcher: host go/num_runs, processor start/ack, run results.
// The log read port exists only when RUN_LAUNCHER_LOG_EN is defined.
interface run_launcher_if #(
  parameter int RUNS_W = 4,
  parameter int CNT_W  = 16
);
  logic              go;
  logic [RUNS_W-1:0] num_runs;
  logic              ack;
  logic              start;
  logic              busy;
  logic [RUNS_W-1:0] run_idx;
  logic              run_valid;
  logic [CNT_W-1:0]  run_cycles;
  logic              run_timeout;
  logic              done_all;
  logic              any_timeout;
`ifdef RUN_LAUNCHER_LOG_EN
  logic [RUNS_W-1:0] log_addr;
  logic [CNT_W:0]    log_data;
`endif

  // master is the launcher itself; slave is the host/processor side driving it.
  modport master (
`ifdef RUN_LAUNCHER_LOG_EN
    input  log_addr,
    output log_data,
`endif
    input  go, num_runs, ack,
    output start, busy, run_idx, run_valid, run_cycles, run_timeout, done_all, any_timeout
  );

  modport slave (
`ifdef RUN_LAUNCHER_LOG_EN
    output log_addr,
    input  log_data,
`endif
    output go, num_runs, ack,
    input  start, busy, run_idx, run_valid, run_cycles, run_timeout, done_all, any_timeout
  );
endinterface

// File: rtl/run_launcher.sv
// Start/ack initiator: runs num_runs programs back-to-back, timing each run and flagging timeouts.
// Optional per-run result log enabled with `define RUN_LAUNCHER_LOG_EN.
module run_launcher #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4096,
  parameter int CNT_W        = 16,
  parameter int RUNS_W       = 4
) (
  input  logic           clk,
  input  logic           reset,
  run_launcher_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_REPORT,
    ST_FINISH
  } state_e;

  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_CYCLES);
  localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [RUNS_W-1:0] IDX_ONE    = RUNS_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic [RUNS_W-1:0] run_idx_q, run_idx_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic              run_timeout_q, run_timeout_d;
  logic              any_timeout_q, any_timeout_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              run_valid_q, run_valid_d;
  logic              done_all_q, done_all_d;
  logic              last_run;

  assign last_run = (run_idx_q == runs_q - IDX_ONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      runs_q        <= '0;
      run_idx_q     <= '0;
      run_cycles_q  <= '0;
      run_timeout_q <= 1'b0;
      any_timeout_q <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      run_valid_q   <= 1'b0;
      done_all_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      runs_q        <= runs_d;
      run_idx_q     <= run_idx_d;
      run_cycles_q  <= run_cycles_d;
      run_timeout_q <= run_timeout_d;
      any_timeout_q <= any_timeout_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      run_valid_q   <= run_valid_d;
      done_all_q    <= done_all_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.go) state_d = (bus.num_runs == '0) ? ST_FINISH : ST_START;
      ST_START:  if (cnt_q == START_LAST) state_d = ST_WAIT;
      ST_WAIT:   if (bus.ack || (cnt_q == TIMEOUT_C)) state_d = ST_REPORT;
      ST_REPORT: state_d = last_run ? ST_FINISH : ST_START;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so start/valid/done are glitch-free flops.
  always_comb begin
    cnt_d         = cnt_q;
    runs_d        = runs_q;
    run_idx_d     = run_idx_q;
    run_cycles_d  = run_cycles_q;
    run_timeout_d = run_timeout_q;
    any_timeout_d = any_timeout_q;
    start_d       = (state_d == ST_START);
    busy_d        = (state_d != ST_IDLE);
    run_valid_d   = (state_d == ST_REPORT);
    done_all_d    = (state_d == ST_FINISH);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          runs_d        = bus.num_runs;
          run_idx_d     = '0;
          any_timeout_d = 1'b0;
          cnt_d         = CNT_ONE;
        end
      end
      ST_START: cnt_d = (cnt_q == START_LAST) ? CNT_ONE : cnt_q + CNT_ONE;
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        // ack wins over a simultaneous timeout; both report TIMEOUT cycles in that case.
        if (bus.ack) begin
          run_cycles_d  = cnt_q;
          run_timeout_d = 1'b0;
        end else if (cnt_q == TIMEOUT_C) begin
          run_cycles_d  = TIMEOUT_C;
          run_timeout_d = 1'b1;
          any_timeout_d = 1'b1;
        end
      end
      ST_REPORT: begin
        if (!last_run) begin
          run_idx_d = run_idx_q + IDX_ONE;
          cnt_d     = CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  assign bus.start       = start_q;
  assign bus.busy        = busy_q;
  assign bus.run_idx     = run_idx_q;
  assign bus.run_valid   = run_valid_q;
  assign bus.run_cycles  = run_cycles_q;
  assign bus.run_timeout = run_timeout_q;
  assign bus.done_all    = done_all_q;
  assign bus.any_timeout = any_timeout_q;

`ifdef RUN_LAUNCHER_LOG_EN
  logic [CNT_W:0] log_q [2**RUNS_W];

  // NOTE: the log is a small flop array, so it takes the async reset; a go never clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**RUNS_W; i++) log_q[i] <= '0;
    end else if (state_q == ST_REPORT) begin
      log_q[run_idx_q] <= {run_timeout_q, run_cycles_q};
    end
  end

  assign bus.log_data = log_q[bus.log_addr];
`endif

endmodule
